// File: rtl/imem_read_responder.sv
// -----------------------------------------------------------------------------
// imem_read_responder
//
// Instruction-memory responder for the fetch-stage read handshake. A read
// request is accepted only while idle; the word is returned a fixed
// READ_LATENCY cycles later together with a one-cycle readFin pulse. Only one
// read is ever in flight and requests are never queued. A side-band
// program-load port fills the word-addressed array in any state.
//
// Optional feature macro: IMEM_RESP_ERR_EN
//   When defined, adds output mem_read_err, flagging responses whose captured
//   address was misaligned or out of range.
//
// Ports
//   clk            in   clock, all logic on posedge
//   rst            in   synchronous reset, active-low
//   mem_readEn     in   read request from fetch
//   mem_read_addr  in   byte address of the read (word index = addr[DEPTH_LOG2+1:2])
//   mem_read_data  out  registered read data, held until the next response
//   readFin        out  one-cycle pulse, mem_read_data valid this cycle
//   busy           out  request in flight
//   mem_read_err   out  (IMEM_RESP_ERR_EN only) response address was bad
//   prog_wrEn      in   program-load write strobe
//   prog_wr_addr   in   program-load byte address (low 2 bits ignored)
//   prog_wr_data   in   program-load word
// -----------------------------------------------------------------------------
module imem_read_responder #(
  parameter int              XLEN         = 32,
  parameter int              ADDR_SIZE    = 32,
  parameter int              DEPTH_LOG2   = 10,
  parameter int              READ_LATENCY = 2,
  parameter logic [XLEN-1:0] OOR_DATA     = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_readEn,
  input  logic [ADDR_SIZE-1:0] mem_read_addr,
  output logic [XLEN-1:0]      mem_read_data,
  output logic                 readFin,
  output logic                 busy,
`ifdef IMEM_RESP_ERR_EN
  output logic                 mem_read_err,
`endif
  input  logic                 prog_wrEn,
  input  logic [ADDR_SIZE-1:0] prog_wr_addr,
  input  logic [XLEN-1:0]      prog_wr_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]        data_q;
  logic                   err_q;
  logic                   load_s;
  logic [XLEN-1:0]        mem_q [DEPTH];

  // Address decode for the captured read and for the program-load write.
  logic                   rd_oor_s, rd_mis_s, wr_oor_s;
  logic [DEPTH_LOG2-1:0]  rd_idx_s, wr_idx_s;
  logic [XLEN-1:0]        rd_word_s;
  logic                   unused_s;

  assign rd_idx_s  = addr_q[DEPTH_LOG2+1:2];
  assign wr_idx_s  = prog_wr_addr[DEPTH_LOG2+1:2];
  assign rd_oor_s  = |addr_q[ADDR_SIZE-1:DEPTH_LOG2+2];
  assign wr_oor_s  = |prog_wr_addr[ADDR_SIZE-1:DEPTH_LOG2+2];
  assign rd_mis_s  = |addr_q[1:0];
  assign rd_word_s = rd_oor_s ? OOR_DATA : mem_q[rd_idx_s];
  // Byte-offset bits of the write address carry no meaning for a word array.
  assign unused_s  = ^{prog_wr_addr[1:0], rd_mis_s};

  // Program-load array write; contents are not reset, writes blocked in reset.
  always_ff @(posedge clk) begin
    if (rst && prog_wrEn && !wr_oor_s) begin
      mem_q[wr_idx_s] <= prog_wr_data;
    end
  end

  // State register plus response data/error registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      addr_q  <= {ADDR_SIZE{1'b0}};
      data_q  <= {XLEN{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (load_s) begin
        // Non-blocking read of mem_q returns the pre-write word on a collision.
        data_q <= rd_word_s;
        err_q  <= rd_oor_s | rd_mis_s;
      end
    end
  end

  // Next-state logic. WAIT always holds at least one edge so that readFin
  // lands in the cycle after edge N+READ_LATENCY, including READ_LATENCY==1
  // (counter starts at zero and the load happens on the next edge).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_readEn) begin
          addr_d  = mem_read_addr;
          cnt_d   = CW'(READ_LATENCY - 1);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          load_s  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        // A held readEn is only seen again from the following IDLE cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; all outputs come straight from registers.
  always_comb begin
    readFin       = (state_q == RESP);
    busy          = (state_q != IDLE);
    mem_read_data = data_q;
`ifdef IMEM_RESP_ERR_EN
    mem_read_err  = err_q;
`endif
  end

`ifndef IMEM_RESP_ERR_EN
  logic unused_err_s;
  assign unused_err_s = err_q ^ unused_s;
`else
  logic unused_err_s;
  assign unused_err_s = unused_s;
`endif

endmodule
